// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong voice.
// Holds the exciter state encoding, the noise LFSR polynomial and seed,
// the default sample width shared with the averaging filter, and the
// single-step LFSR update used by both the LFSR register and the top level.
package ks_pkg;

  typedef enum logic {IDLE, BURST} ks_state_e;

  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_2D5F;
  localparam int          BIT_WIDTH_DEFAULT = 16;

  // One step of the right-shifting Galois LFSR (x^32+x^22+x^2+x+1).
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/ks_lfsr.sv
// 32-bit Galois LFSR noise register.
// Ports:
//   m_clk  - system clock
//   reset  - asynchronous active-high, reloads LFSR_SEED
//   step   - advance one step on this edge
//   state  - current LFSR contents
module ks_lfsr
  import ks_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic        m_clk,
  input  logic        reset,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/ks_exciter.sv
// Karplus-Strong excitation source: on an accepted pluck emits one burst of
// len = clamp(period, 2, MAX_PERIOD) attenuated pseudo-random samples on a
// valid/ready stream, one sample per accepted beat.
// Ports:
//   m_clk       - system clock
//   reset       - asynchronous active-high, clears all state
//   pluck       - trigger request, honoured only when idle
//   period      - burst length, captured on an accepted pluck
//   amplitude   - arithmetic right shift 0..3, captured on an accepted pluck
//   out_ready   - downstream accepts the presented sample
//   out_valid   - out_sample holds a valid sample
//   out_sample  - signed noise sample
//   busy        - burst in progress
//   done        - one-cycle pulse after the last sample is accepted
module ks_exciter
  import ks_pkg::*;
#(
  parameter int          BIT_WIDTH  = BIT_WIDTH_DEFAULT,
  parameter int          MAX_PERIOD = 2048,
  parameter int          LEN_W      = $clog2(MAX_PERIOD + 1),
  parameter logic [31:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                        m_clk,
  input  logic                        reset,
  input  logic                        pluck,
  input  logic [LEN_W-1:0]            period,
  input  logic [1:0]                  amplitude,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [BIT_WIDTH-1:0] out_sample,
  output logic                        busy,
  output logic                        done
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] p);
    if (p < LEN_W'(2))               return LEN_W'(2);
    else if (p > LEN_W'(MAX_PERIOD)) return LEN_W'(MAX_PERIOD);
    else                             return p;
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] attenuate(
    input logic [BIT_WIDTH-1:0] raw,
    input logic [1:0]           sh
  );
    logic signed [BIT_WIDTH-1:0] v;
    v = $signed(raw);
    return v >>> sh;
  endfunction

  ks_state_e                   state_p0, state_nx;
  logic [LEN_W-1:0]            len_p0, count_p0;
  logic [1:0]                  shift_p0;
  logic                        vld_p0, done_p0;
  logic signed [BIT_WIDTH-1:0] sample_p0;
  logic [31:0]                 lfsr_state;
  logic [BIT_WIDTH-1:0]        cur_top, nx_top;
  logic                        beat, last_beat, start;

  assign beat      = vld_p0 & out_ready;
  assign last_beat = beat & (count_p0 == len_p0 - LEN_W'(1));

  // The sample after an accepted beat comes from the LFSR value the beat
  // advances to, so it is computed here rather than waiting a cycle.
  assign cur_top = BIT_WIDTH'(lfsr_state >> (32 - BIT_WIDTH));
  assign nx_top  = BIT_WIDTH'(lfsr_next(lfsr_state) >> (32 - BIT_WIDTH));

  ks_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .m_clk (m_clk),
    .reset (reset),
    .step  (beat),
    .state (lfsr_state)
  );

  always_comb begin
    state_nx = state_p0;
    start    = 1'b0;
    case (state_p0)
      IDLE: begin
        if (pluck) begin
          state_nx = BURST;
          start    = 1'b1;
        end
      end
      BURST: begin
        if (last_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: control, counter and registered output sample
  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      state_p0  <= IDLE;
      len_p0    <= '0;
      count_p0  <= '0;
      shift_p0  <= '0;
      vld_p0    <= 1'b0;
      done_p0   <= 1'b0;
      sample_p0 <= '0;
    end else begin
      state_p0 <= state_nx;
      done_p0  <= last_beat;
      if (start) begin
        len_p0    <= clamp_len(period);
        shift_p0  <= amplitude;
        count_p0  <= '0;
        vld_p0    <= 1'b1;
        sample_p0 <= attenuate(cur_top, amplitude);
      end else if (beat) begin
        count_p0 <= count_p0 + LEN_W'(1);
        if (last_beat) begin
          vld_p0 <= 1'b0;
        end else begin
          sample_p0 <= attenuate(nx_top, shift_p0);
        end
      end
    end
  end

  assign out_valid  = vld_p0;
  assign out_sample = sample_p0;
  assign busy       = (state_p0 == BURST);
  assign done       = done_p0;

endmodule
